// File: rtl/tp84_rom_loader.sv
// ---------------------------------------------------------------------------
// tp84_rom_loader
//
// Bridges the HPS download interface to the Time Pilot '84 core.
//  - Index 0 (ROM) bytes are split into six per-chip write ports. Each port
//    sees an address relative to the start of its own region.
//  - Index 1 (set info) byte at address 0 supplies the is_set3 flag.
//  - Index 254 (DIP) bytes at addresses 0 and 1 supply the two DIP bytes.
//  - The core is held in reset (core_hold) from the start of a ROM download
//    until HOLD_CYCLES clocks after the download ends.
//
// Ports:
//   clk_49m         system clock
//   reset           synchronous, active-low reset
//   ioctl_download  download in progress
//   ioctl_index     download type (0 ROM, 1 set info, 254 DIP)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address within the download
//   ioctl_dout      byte data
//   rom_wr          one-hot ROM write strobe, bit n = region n
//   rom_addr        region-relative ROM address
//   rom_data        ROM write data
//   dip_sw0/1       raw DIP bytes
//   is_set3         bit 0 of the set-info byte
//   core_hold       high = keep the core in reset
//   load_done       one-cycle pulse when core_hold releases
//   load_error      sticky: a ROM byte fell beyond the last region
//   byte_count      ROM bytes accepted in the current/last download
// ---------------------------------------------------------------------------
module tp84_rom_loader #(
  parameter logic [24:0] R0_END      = 25'h08000,
  parameter logic [24:0] R1_END      = 25'h0A000,
  parameter logic [24:0] R2_END      = 25'h0C000,
  parameter logic [24:0] R3_END      = 25'h10000,
  parameter logic [24:0] R4_END      = 25'h18000,
  parameter logic [24:0] R5_END      = 25'h19000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [5:0]  rom_wr,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  dip_sw0,
  output logic [7:0]  dip_sw1,
  output logic        is_set3,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [24:0] byte_count
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Every region is at most 32 KiB, so the region-relative address only
  // needs the low 15 bits of the byte address and of the region base
  // (the subtraction is exact modulo 2^15).
  localparam logic [14:0] BASE1 = R0_END[14:0];
  localparam logic [14:0] BASE2 = R1_END[14:0];
  localparam logic [14:0] BASE3 = R2_END[14:0];
  localparam logic [14:0] BASE4 = R3_END[14:0];
  localparam logic [14:0] BASE5 = R4_END[14:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;

  logic             rom_start;
  logic             rom_strobe_p0;
  logic [5:0]       sel_p0;
  logic [14:0]      offs_p0;
  logic             in_rng_p0;
  logic             vld_p0;
  logic             oor_p0;
  logic             set_wr_p0;
  logic             dip_wr_p0;

  // ---- stage p0: decode of the incoming download byte ----
  assign rom_start     = ioctl_download && (ioctl_index == 8'd0);
  assign rom_strobe_p0 = (state == LOADING) && ioctl_wr && (ioctl_index == 8'd0);
  assign set_wr_p0     = ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0);
  assign dip_wr_p0     = ioctl_wr && (ioctl_index == 8'd254) &&
                         (ioctl_addr[24:3] == 22'd0);

  always_comb begin
    sel_p0    = 6'b000000;
    offs_p0   = 15'd0;
    in_rng_p0 = 1'b1;
    if (ioctl_addr < R0_END) begin
      sel_p0  = 6'b000001;
      offs_p0 = ioctl_addr[14:0];
    end else if (ioctl_addr < R1_END) begin
      sel_p0  = 6'b000010;
      offs_p0 = ioctl_addr[14:0] - BASE1;
    end else if (ioctl_addr < R2_END) begin
      sel_p0  = 6'b000100;
      offs_p0 = ioctl_addr[14:0] - BASE2;
    end else if (ioctl_addr < R3_END) begin
      sel_p0  = 6'b001000;
      offs_p0 = ioctl_addr[14:0] - BASE3;
    end else if (ioctl_addr < R4_END) begin
      sel_p0  = 6'b010000;
      offs_p0 = ioctl_addr[14:0] - BASE4;
    end else if (ioctl_addr < R5_END) begin
      sel_p0  = 6'b100000;
      offs_p0 = ioctl_addr[14:0] - BASE5;
    end else begin
      in_rng_p0 = 1'b0;
    end
  end

  assign vld_p0 = rom_strobe_p0 && in_rng_p0;
  assign oor_p0 = rom_strobe_p0 && !in_rng_p0;

  // ---- stage p1: registered outputs and load sequencing ----
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      rom_wr     <= 6'b000000;
      rom_addr   <= 15'd0;
      rom_data   <= 8'h00;
      dip_sw0    <= 8'h00;
      dip_sw1    <= 8'h00;
      is_set3    <= 1'b0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      byte_count <= 25'd0;
    end else begin
      rom_wr    <= 6'b000000;
      load_done <= 1'b0;

      // A strobe on the cycle the download drops is still taken, because
      // the state is LOADING on that edge; its pulse lands in FLUSH.
      if (vld_p0) begin
        rom_wr     <= sel_p0;
        rom_addr   <= offs_p0;
        rom_data   <= ioctl_dout;
        byte_count <= byte_count + 25'd1;
      end
      if (oor_p0) begin
        load_error <= 1'b1;
      end

      if (set_wr_p0) begin
        is_set3 <= ioctl_dout[0];
      end
      if (dip_wr_p0) begin
        case (ioctl_addr[2:0])
          3'd0:    dip_sw0 <= ioctl_dout;
          3'd1:    dip_sw1 <= ioctl_dout;
          default: ;
        endcase
      end

      // ROM strobes are only accepted in LOADING, so the counter and error
      // clears below never collide with the datapath updates above.
      case (state)
        IDLE, DONE: begin
          if (rom_start) begin
            state      <= LOADING;
            core_hold  <= 1'b1;
            byte_count <= 25'd0;
            load_error <= 1'b0;
          end
        end
        LOADING: begin
          if (!ioctl_download) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= DONE;
            core_hold <= 1'b0;
            load_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
